// File: rtl/processador_param.sv
// processador_param: 8-register, DATA_W-bit multicycle CPU with its own fetch
// through a 1-cycle-latency synchronous memory port.
// Opcodes: mv, mvi, add, sub, ld, st, mvnz, and the optional logic op 111.
// Optional feature macro: PROC_LOGIC_EN (opcode 111 = and; otherwise it is a nop).
module processador_param #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,   // active-high asynchronous reset
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] ADDR,
    output logic [DATA_W-1:0] DOUT,
    output logic              W_D,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [2:0]        Tstep,
    output logic [DATA_W-1:0] Rx_data,
    output logic [DATA_W-1:0] Ry_data
);

    typedef enum logic [2:0] {
        StT0 = 3'd0,
        StT1 = 3'd1,
        StT2 = 3'd2,
        StT3 = 3'd3,
        StT4 = 3'd4,
        StT5 = 3'd5
    } step_e;

    localparam logic [2:0] OpMv    = 3'b000;
    localparam logic [2:0] OpMvi   = 3'b001;
    localparam logic [2:0] OpAdd   = 3'b010;
    localparam logic [2:0] OpSub   = 3'b011;
    localparam logic [2:0] OpLd    = 3'b100;
    localparam logic [2:0] OpSt    = 3'b101;
    localparam logic [2:0] OpMvnz  = 3'b110;
    localparam logic [2:0] OpLogic = 3'b111;

    localparam logic [DATA_W-1:0] PcStep = DATA_W'(1);

    step_e             r_step;
    step_e             w_step_d;
    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;
    logic [8:0]        r_ir;

    logic [2:0]        w_op;
    logic [2:0]        w_rx;
    logic [2:0]        w_ry;
    logic              w_is_alu;
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_alu;
    logic              w_done;
    logic              w_wd;
    logic              w_rx_we;
    logic              w_pc_inc;
    logic              w_addr_ld;
    logic              w_ir_ld;
    logic              w_a_ld;
    logic              w_g_ld;
    logic              w_dout_ld;

    assign w_op = r_ir[8:6];
    assign w_rx = r_ir[5:3];
    assign w_ry = r_ir[2:0];

`ifdef PROC_LOGIC_EN
    assign w_is_alu = (w_op == OpAdd) || (w_op == OpSub) || (w_op == OpLogic);
`else
    assign w_is_alu = (w_op == OpAdd) || (w_op == OpSub);
`endif

    assign ADDR     = r_addr;
    assign DOUT     = r_dout;
    assign W_D      = w_wd;
    assign Done     = w_done;
    assign BusWires = w_bus;
    assign Tstep    = r_step;
    assign Rx_data  = r_regs[w_rx];
    assign Ry_data  = r_regs[w_ry];

    // Step sequencing and per-step control: who drives the bus and who loads from it
    always_comb begin
        w_step_d  = r_step;
        w_bus     = '0;
        w_done    = 1'b0;
        w_wd      = 1'b0;
        w_rx_we   = 1'b0;
        w_pc_inc  = 1'b0;
        w_addr_ld = 1'b0;
        w_ir_ld   = 1'b0;
        w_a_ld    = 1'b0;
        w_g_ld    = 1'b0;
        w_dout_ld = 1'b0;
        unique case (r_step)
            StT0: begin
                if (Run) begin
                    w_bus     = r_regs[7];
                    w_addr_ld = 1'b1;
                    w_pc_inc  = 1'b1;
                    w_step_d  = StT1;
                end
            end
            StT1: w_step_d = StT2;
            StT2: begin
                w_ir_ld  = 1'b1;
                w_step_d = StT3;
            end
            StT3: begin
                case (w_op)
                    OpMv: begin
                        w_bus   = r_regs[w_ry];
                        w_rx_we = 1'b1;
                        w_done  = 1'b1;
                    end
                    OpMvnz: begin
                        w_done = 1'b1;
                        if (r_g != '0) begin
                            w_bus   = r_regs[w_ry];
                            w_rx_we = 1'b1;
                        end
                    end
                    OpMvi: begin
                        w_bus     = r_regs[7];
                        w_addr_ld = 1'b1;
                        w_pc_inc  = 1'b1;
                    end
                    OpLd, OpSt: begin
                        w_bus     = r_regs[w_ry];
                        w_addr_ld = 1'b1;
                    end
                    default: begin
                        if (w_is_alu) begin
                            w_bus  = r_regs[w_rx];
                            w_a_ld = 1'b1;
                        end else begin
                            w_done = 1'b1;  // opcode 111 without the logic op: nop
                        end
                    end
                endcase
                w_step_d = w_done ? StT0 : StT4;
            end
            StT4: begin
                w_step_d = StT5;
                if (w_is_alu) begin
                    w_bus  = r_regs[w_ry];
                    w_g_ld = 1'b1;
                end else if (w_op == OpSt) begin
                    w_bus     = r_regs[w_rx];
                    w_dout_ld = 1'b1;
                end
            end
            StT5: begin
                w_step_d = StT0;
                w_done   = 1'b1;
                if (w_is_alu) begin
                    w_bus   = r_g;
                    w_rx_we = 1'b1;
                end else if ((w_op == OpMvi) || (w_op == OpLd)) begin
                    w_bus   = DIN;
                    w_rx_we = 1'b1;
                end else if (w_op == OpSt) begin
                    w_wd = 1'b1;
                end
            end
            default: w_step_d = StT0;
        endcase
    end

    // ALU: A combined with the bus (which carries Ry in T4)
    always_comb begin
        case (w_op)
            OpSub:   w_alu = r_a - w_bus;
`ifdef PROC_LOGIC_EN
            OpLogic: w_alu = r_a & w_bus;
`endif
            default: w_alu = r_a + w_bus;
        endcase
    end

    // Step register
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_step <= StT0;
        end else begin
            r_step <= w_step_d;
        end
    end

    // Register file; an Rx write never shares a step with the PC increment
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_pc_inc) begin
                r_regs[7] <= r_regs[7] + PcStep;
            end
            if (w_rx_we) begin
                r_regs[w_rx] <= w_bus;
            end
        end
    end

    // IR, operand/result registers and the memory-port registers
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_ir   <= '0;
            r_a    <= '0;
            r_g    <= '0;
            r_addr <= '0;
            r_dout <= '0;
        end else begin
            if (w_ir_ld) begin
                r_ir <= DIN[8:0];
            end
            if (w_a_ld) begin
                r_a <= w_bus;
            end
            if (w_g_ld) begin
                r_g <= w_alu;
            end
            if (w_addr_ld) begin
                r_addr <= w_bus;
            end
            if (w_dout_ld) begin
                r_dout <= w_bus;
            end
        end
    end

endmodule

// File: tb/tb_processador_param.sv
// Bench for processador_param: a 16-bit and a 9-bit instance, each on its own
// synchronous RAM model, running hand-assembled programs with hand-computed results.
module tb_processador_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, run16, wd16, done16;
    logic [15:0] din16, addr16, dout16, bus16, rx16, ry16;
    logic [2:0]  ts16;
    logic        rst9, run9, wd9, done9;
    logic [8:0]  din9, addr9, dout9, bus9, rx9, ry9;
    logic [2:0]  ts9;

    logic [15:0] mem16 [512];
    logic [8:0]  mem9  [512];
    logic        ld_en = 1'b0;
    logic        ld_sel = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    int n_tests = 0;
    int n_fail = 0;
    int wd16_cnt = 0;

    processador_param #(.DATA_W(16)) dut16 (
        .Clock(clk), .Resetn(rst16), .Run(run16), .DIN(din16), .ADDR(addr16),
        .DOUT(dout16), .W_D(wd16), .Done(done16), .BusWires(bus16), .Tstep(ts16),
        .Rx_data(rx16), .Ry_data(ry16)
    );

    processador_param #(.DATA_W(9)) dut9 (
        .Clock(clk), .Resetn(rst9), .Run(run9), .DIN(din9), .ADDR(addr9),
        .DOUT(dout9), .W_D(wd9), .Done(done9), .BusWires(bus9), .Tstep(ts9),
        .Rx_data(rx9), .Ry_data(ry9)
    );

    // RAM models: 1-cycle read latency, write on the edge ending a W_D cycle
    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem16[ld_addr] <= ld_data;
        else if (wd16)        mem16[addr16[8:0]] <= dout16;
        din16 <= mem16[addr16[8:0]];
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel) mem9[ld_addr] <= ld_data[8:0];
        else if (wd9)        mem9[addr9] <= dout9;
        din9 <= mem9[addr9];
    end

    always @(posedge clk) begin
        if (wd16) wd16_cnt <= wd16_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input bit sel, input int a, input int d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = a[8:0];
        ld_data = d[15:0];
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Called at a negedge in T0 with Run high; returns at the negedge of the next T0
    task automatic run_instr(input bit sel, input int exp_cyc, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        check_eq({tag, "_t0"}, 32'(sel ? ts9 : ts16), 32'd0);
        while (!seen && n < 20) begin
            n++;
            if (sel ? done9 : done16) seen = 1'b1;
            @(negedge clk);
        end
        check_eq({tag, "_cycles"}, seen ? 32'(n) : 32'd99, 32'(exp_cyc));
    endtask

    int prog16 [17] = '{'h050, 'h001, 'h060, 'h00A, 'h0A2, 'h0E2, 'h19A, 'h0D2, 'h1AC,
                        'h048, 'h020, 'h161, 'h131, 'h040, 'h0F6, 'h1C4, 'h039};
    int prog9 [10]  = '{'h040, 'h1FF, 'h048, 'h001, 'h081, 'h058, 'h1F5, 'h1D9,
                        'h078, 'h1FF};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int and_cyc;
        int exp_r0;
        int exp_g;
        int exp_r3;
`ifdef PROC_LOGIC_EN
        and_cyc = 6; exp_r0 = 'h02; exp_g = 'h02; exp_r3 = 'h001;
`else
        and_cyc = 4; exp_r0 = 'hF6; exp_g = 'h00; exp_r3 = 'h1F5;
`endif
        rst16 = 1'b1; run16 = 1'b0;
        rst9  = 1'b1; run9  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) load(1'b0, i, prog16[i]);
        load(1'b0, 'h21, 'h165);
        for (int i = 0; i < 10; i++) load(1'b1, i, prog9[i]);
        load(1'b1, 'h1FF, 'h013);

        // Reset state
        check_eq("rst_tstep", 32'(ts16), 32'd0);
        check_eq("rst_done", 32'(done16), 32'd0);
        check_eq("rst_wd", 32'(wd16), 32'd0);
        check_eq("rst_bus", 32'(bus16), 32'd0);
        check_eq("rst_addr", 32'(addr16), 32'd0);
        check_eq("rst_dout", 32'(dout16), 32'd0);
        check_eq("rst_rx", 32'(rx16), 32'd0);

        // 16-bit program
        rst16 = 1'b0; run16 = 1'b1;
        run_instr(1'b0, 6, "mvi_r2");
        check_eq("mvi_r2_val", 32'(dut16.r_regs[2]), 32'd1);
        run_instr(1'b0, 6, "mvi_r4");
        check_eq("mvi_r4_val", 32'(dut16.r_regs[4]), 32'd10);
        check_eq("pc_after_mvi", 32'(dut16.r_regs[7]), 32'd4);
        run_instr(1'b0, 6, "add");
        check_eq("add_r4", 32'(dut16.r_regs[4]), 32'd11);
        run_instr(1'b0, 6, "sub");
        check_eq("sub_r4", 32'(dut16.r_regs[4]), 32'd10);
        check_eq("sub_g", 32'(dut16.r_g), 32'd10);
        run_instr(1'b0, 4, "mvnz_taken");
        check_eq("mvnz_r3", 32'(dut16.r_regs[3]), 32'd1);
        run_instr(1'b0, 6, "sub_self");
        check_eq("sub_self_r2", 32'(dut16.r_regs[2]), 32'd0);
        check_eq("sub_self_g", 32'(dut16.r_g), 32'd0);
        run_instr(1'b0, 4, "mvnz_skip");
        check_eq("mvnz_r5", 32'(dut16.r_regs[5]), 32'd0);
        run_instr(1'b0, 6, "mvi_r1");
        check_eq("mvi_r1_val", 32'(dut16.r_regs[1]), 32'h20);
        c0 = wd16_cnt;
        run_instr(1'b0, 6, "st");
        check_eq("st_wd_pulses", 32'(wd16_cnt - c0), 32'd1);
        check_eq("st_mem", 32'(mem16['h20]), 32'd10);
        run_instr(1'b0, 6, "ld");
        check_eq("ld_r6", 32'(dut16.r_regs[6]), 32'd10);
        run_instr(1'b0, 6, "mvi_r0");
        check_eq("mvi_r0_val", 32'(dut16.r_regs[0]), 32'hF6);
        run_instr(1'b0, and_cyc, "op111");
        check_eq("op111_r0", 32'(dut16.r_regs[0]), 32'(exp_r0));
        check_eq("op111_g", 32'(dut16.r_g), 32'(exp_g));
        run_instr(1'b0, 4, "jump");
        check_eq("jump_pc", 32'(dut16.r_regs[7]), 32'h20);
        run_instr(1'b0, 4, "after_jump");
        check_eq("after_jump_r1", 32'(dut16.r_regs[1]), 32'd0);
        check_eq("after_jump_pc", 32'(dut16.r_regs[7]), 32'h21);

        // st R4,R5 aborted by reset in T4
        c0 = wd16_cnt;
        repeat (4) @(negedge clk);
        check_eq("abort_t4", 32'(ts16), 32'd4);
        check_eq("abort_rx", 32'(rx16), 32'd10);
        check_eq("abort_bus", 32'(bus16), 32'd10);
        rst16 = 1'b1;
        #1;
        check_eq("abort_tstep", 32'(ts16), 32'd0);
        check_eq("abort_done", 32'(done16), 32'd0);
        check_eq("abort_wd", 32'(wd16), 32'd0);
        check_eq("abort_bus0", 32'(bus16), 32'd0);
        check_eq("abort_ry", 32'(ry16), 32'd0);
        check_eq("abort_r4", 32'(dut16.r_regs[4]), 32'd0);
        check_eq("abort_pc", 32'(dut16.r_regs[7]), 32'd0);
        check_eq("abort_addr", 32'(addr16), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("abort_no_write", 32'(wd16_cnt - c0), 32'd0);
        check_eq("abort_mem0", 32'(mem16[0]), 32'h050);

        // 9-bit program
        rst9 = 1'b0; run9 = 1'b1;
        check_eq("w9_bus_t0", 32'(bus9), 32'd0);
        run_instr(1'b1, 6, "w9_mvi_r0");
        check_eq("w9_r0", 32'(dut9.r_regs[0]), 32'h1FF);
        run_instr(1'b1, 6, "w9_mvi_r1");
        run_instr(1'b1, 6, "w9_add_wrap");
        check_eq("w9_wrap_r0", 32'(dut9.r_regs[0]), 32'd0);
        check_eq("w9_rx_data", 32'(rx9), 32'd0);
        check_eq("w9_ry_data", 32'(ry9), 32'd1);
        run_instr(1'b1, 6, "w9_mvi_r3");
        run_instr(1'b1, and_cyc, "w9_op111");
        check_eq("w9_op111_r3", 32'(dut9.r_regs[3]), 32'(exp_r3));
        run_instr(1'b1, 6, "w9_mvi_pc");
        check_eq("w9_pc_jump", 32'(dut9.r_regs[7]), 32'h1FF);
        run_instr(1'b1, 4, "w9_fetch_wrap");
        check_eq("w9_pc_wrap", 32'(dut9.r_regs[7]), 32'd0);
        check_eq("w9_r2", 32'(dut9.r_regs[2]), 32'(exp_r3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
